// File: rtl/dcache_pkg.sv
// Shared types, default geometry and the store byte-merge helper for the data cache.
package dcache_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_SET_LOG  = 6;
  localparam int DEF_LINE_LOG = 2;
  localparam int IDX_W        = DEF_SET_LOG;
  localparam int OFF_W        = DEF_LINE_LOG;
  localparam int TAG_W        = DEF_ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WBACK  = 2'd1,
    REFILL = 2'd2
  } state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one whole-line write port.
module dcache_line_array #(
  parameter int SET_LOG  = 6,
  parameter int LINE_LOG = 2,
  parameter int TAG_W    = 22
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SET_LOG-1:0]               rd_idx,
  output logic                             rd_valid,
  output logic                             rd_dirty,
  output logic [TAG_W-1:0]                 rd_tag,
  output logic [2**LINE_LOG-1:0][31:0]     rd_line,
  input  logic                             wr_en,
  input  logic [SET_LOG-1:0]               wr_idx,
  input  logic [TAG_W-1:0]                 wr_tag,
  input  logic                             wr_dirty,
  input  logic [2**LINE_LOG-1:0][31:0]     wr_line
);

  localparam int lines = 2**SET_LOG;

  logic [lines-1:0]                  valid;
  logic [lines-1:0]                  dirty;
  logic [TAG_W-1:0]                  tags [lines];
  logic [2**LINE_LOG-1:0][31:0]      data [lines];

  // Only the status bits need reset; tags and data are don't-care while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_line  = data[rd_idx];

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache for the MEM stage.
// Optional hit/miss counters are enabled with DCACHE_STATS_EN.
//
// state  | meaning
// IDLE   | serving hits; a miss picks WBACK (dirty victim) or REFILL
// WBACK  | writing victim words 0..last to memory
// REFILL | reading missed line words 0..last, install on last ack
module data_cache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int SET_LOG  = DEF_SET_LOG,
  parameter int LINE_LOG = DEF_LINE_LOG
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST_N,
  input  logic              CpuReq,
  input  logic [3:0]        CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [31:0]       CpuWData,
  output logic [31:0]       CpuRData,
  output logic              DCacheMiss,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [31:0]       MemWData,
  input  logic [31:0]       MemRData,
  input  logic              MemAck
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       HitCount,
  output logic [31:0]       MissCount
`endif
);

  localparam int words = 2**LINE_LOG;
  localparam int tag_w = ADDR_W - SET_LOG - LINE_LOG - 2;
  localparam logic [LINE_LOG-1:0] off_zero = '0;

  logic [tag_w-1:0]    cpu_tag;
  logic [SET_LOG-1:0]  cpu_idx;
  logic [LINE_LOG-1:0] cpu_off;
  logic [1:0]          unused_addr_bits;

  assign cpu_tag          = CpuAddr[ADDR_W-1 -: tag_w];
  assign cpu_idx          = CpuAddr[SET_LOG+LINE_LOG+1 : LINE_LOG+2];
  assign cpu_off          = CpuAddr[LINE_LOG+1:2];
  assign unused_addr_bits = CpuAddr[1:0];

  state_t                  state;
  logic [LINE_LOG-1:0]     cnt;
  logic [LINE_LOG-1:0]     cnt_nxt;
  logic [tag_w-1:0]        miss_tag;
  logic [SET_LOG-1:0]      miss_idx;
  logic [words-1:0][31:0]  fill_buf;

  logic                    rd_valid, rd_dirty;
  logic [tag_w-1:0]        rd_tag;
  logic [words-1:0][31:0]  rd_line;
  logic [SET_LOG-1:0]      rd_idx;
  logic                    wr_en, wr_dirty;
  logic [SET_LOG-1:0]      wr_idx;
  logic [tag_w-1:0]        wr_tag;
  logic [words-1:0][31:0]  wr_line;

  logic hit, xfer, last;

  // Outside IDLE the array is addressed by the latched miss, so a flushed CpuAddr cannot disturb the burst.
  assign rd_idx     = (state == IDLE) ? cpu_idx : miss_idx;
  assign hit        = CpuReq && (state == IDLE) && rd_valid && (rd_tag == cpu_tag);
  assign DCacheMiss = CpuReq && !hit;
  assign CpuRData   = hit ? rd_line[cpu_off] : 32'd0;
  assign xfer       = MemReq && MemAck;
  assign last       = (cnt == {LINE_LOG{1'b1}});
  assign cnt_nxt    = cnt + 1'b1;

  dcache_line_array #(
    .SET_LOG  (SET_LOG),
    .LINE_LOG (LINE_LOG),
    .TAG_W    (tag_w)
  ) u_lines (
    .clk      (CPU_CLK),
    .rst_n    (CPU_RST_N),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_dirty (wr_dirty),
    .wr_line  (wr_line)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = cpu_idx;
    wr_tag   = cpu_tag;
    wr_dirty = 1'b0;
    wr_line  = rd_line;
    if (state == REFILL && xfer && last) begin
      wr_en              = 1'b1;
      wr_idx             = miss_idx;
      wr_tag             = miss_tag;
      wr_line            = fill_buf;
      wr_line[words-1]   = MemRData;
    end else if (hit && (CpuWe != 4'b0000)) begin
      wr_en              = 1'b1;
      wr_dirty           = 1'b1;
      wr_line[cpu_off]   = byte_merge(rd_line[cpu_off], CpuWData, CpuWe);
    end
  end

  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state    <= IDLE;
      cnt      <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      fill_buf <= '0;
      MemReq   <= 1'b0;
      MemWe    <= 1'b0;
      MemAddr  <= '0;
      MemWData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CpuReq && !hit) begin
            miss_tag <= cpu_tag;
            miss_idx <= cpu_idx;
            cnt      <= '0;
            MemReq   <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state    <= WBACK;
              MemWe    <= 1'b1;
              MemAddr  <= {rd_tag, cpu_idx, off_zero, 2'b00};
              MemWData <= rd_line[0];
            end else begin
              state    <= REFILL;
              MemWe    <= 1'b0;
              MemAddr  <= {cpu_tag, cpu_idx, off_zero, 2'b00};
            end
          end
        end
        WBACK: begin
          if (xfer) begin
            if (last) begin
              state   <= REFILL;
              cnt     <= '0;
              MemWe   <= 1'b0;
              MemAddr <= {miss_tag, miss_idx, off_zero, 2'b00};
            end else begin
              cnt      <= cnt_nxt;
              MemAddr  <= {rd_tag, miss_idx, cnt_nxt, 2'b00};
              MemWData <= rd_line[cnt_nxt];
            end
          end
        end
        REFILL: begin
          if (xfer) begin
            fill_buf[cnt] <= MemRData;
            if (last) begin
              state  <= IDLE;
              cnt    <= '0;
              MemReq <= 1'b0;
            end else begin
              cnt     <= cnt_nxt;
              MemAddr <= {miss_tag, miss_idx, cnt_nxt, 2'b00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (hit) HitCount <= HitCount + 32'd1;
      if (CpuReq && (state == IDLE) && !hit) MissCount <= MissCount + 32'd1;
    end
  end
`endif

endmodule
